dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port 16-bit data memory of the Harvard core.
- Shares the memory between the core load/store unit (port C) and the debug/DMA loader (port D).
- Serialises their accesses into clean one-cycle memory enables and returns read data with a valid strobe.
- Replaces direct level-sensitive read/write control with a clocked, handshaked access sequence.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_pick.sv | 41 ++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - winner selection for the data-memory arbiter
// DMEM_ARBITER_RR_EN: round-robin with last-grant register; otherwise fixed C-over-D priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic c_req,
  input  logic d_req,
  input  logic grant_fire,
  output logic winner
);

`ifdef DMEM_ARBITER_RR_EN
  logic last_gnt;

  // Reset to D so that the first tie after reset goes to C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT_D;
    end else if (grant_fire) begin
      last_gnt <= winner;
    end
  end

  always_comb begin
    winner = PORT_D;
    if (c_req && d_req) begin
      winner = ~last_gnt;
    end else if (c_req) begin
      winner = PORT_C;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, clk, rst_n, d_req, grant_fire};

  assign winner = c_req ? PORT_C : PORT_D;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer for the single-port data memory
// DMEM_ARBITER_RR_EN: enables round-robin arbitration in dmem_arb_pick.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  arb_state_t state;
  logic       owner;
  logic       op_we;
  logic [1:0] cnt;
  logic       winner;
  logic       grant_fire;

  // Grants are combinational so a requester sees acceptance in the cycle it asks.
  assign grant_fire = rst_n && (state == IDLE) && (c_req || d_req);
  assign c_gnt      = grant_fire && (winner == PORT_C);
  assign d_gnt      = grant_fire && (winner == PORT_D);

  dmem_arb_pick u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_req      (c_req),
    .d_req      (d_req),
    .grant_fire (grant_fire),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= PORT_C;
      op_we     <= 1'b0;
      cnt       <= 2'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      c_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_fire) begin
            owner     <= winner;
            op_we     <= (winner == PORT_D) ? d_we : c_we;
            mem_addr  <= (winner == PORT_D) ? d_addr : c_addr;
            mem_wdata <= (winner == PORT_D) ? d_wdata : c_wdata;
            mem_we    <= (winner == PORT_D) ? d_we : c_we;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_we) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            if (owner == PORT_D) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              c_rdata  <= mem_rdata;
              c_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_dmem_arbiter;

`ifdef DMEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [1:0]       c_req, c_we, c_gnt, c_rvalid;
  logic [1:0]       d_req, d_we, d_gnt, d_rvalid;
  logic [1:0]       mem_en, mem_we;
  logic [1:0][7:0]  c_addr, d_addr, mem_addr;
  logic [1:0][15:0] c_wdata, d_wdata, c_rdata, d_rdata, mem_wdata, mem_rdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int L = (g == 0) ? 1 : 3;

    logic [15:0] mem [256];
    logic [15:0] pipe [L];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c_req     (c_req[g]),
      .c_we      (c_we[g]),
      .c_addr    (c_addr[g]),
      .c_wdata   (c_wdata[g]),
      .c_gnt     (c_gnt[g]),
      .c_rvalid  (c_rvalid[g]),
      .c_rdata   (c_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_gnt     (d_gnt[g]),
      .d_rvalid  (d_rvalid[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    // Memory: mem[i]=i, read data valid L cycles after the enable, garbage otherwise.
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      for (int i = 0; i < L; i++) pipe[i] = 16'hDEAD;
    end
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];

    // Transaction-level reference: an access occupies k=0..end cycles after its grant.
    logic [15:0] ref_mem [256];
    int          k;
    bit          busy, own, owe, last_d;
    logic [7:0]  ma;
    logic [15:0] mwd, erd_c, erd_d;

    initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i);
      busy = 0; k = 0; own = 0; owe = 0; last_d = 1; ma = 0; mwd = 0; erd_c = 0; erd_d = 0;
    end

    always @(negedge clk) begin : mdl
      bit gc, gd, en, rdone;
      gc = 0;
      gd = 0;
      if (!rst_n) begin
        busy = 0; k = 0; last_d = 1; ma = 0; mwd = 0; erd_c = 0; erd_d = 0;
      end else begin
        gc = !busy && c_req[g] && (!d_req[g] || !RR || last_d);
        gd = !busy && d_req[g] && !gc;
      end
      en    = busy && (k == 1);
      rdone = busy && !owe && (k == L + 2);
      if (rdone) begin
        if (own) erd_d = ref_mem[ma];
        else     erd_c = ref_mem[ma];
      end
      check($sformatf("i%0d.c_gnt", g),     32'(c_gnt[g]),     32'(gc));
      check($sformatf("i%0d.d_gnt", g),     32'(d_gnt[g]),     32'(gd));
      check($sformatf("i%0d.mem_en", g),    32'(mem_en[g]),    32'(en));
      check($sformatf("i%0d.mem_we", g),    32'(mem_we[g]),    32'(en && owe));
      check($sformatf("i%0d.mem_addr", g),  32'(mem_addr[g]),  32'(ma));
      check($sformatf("i%0d.mem_wdata", g), 32'(mem_wdata[g]), 32'(mwd));
      check($sformatf("i%0d.c_rvalid", g),  32'(c_rvalid[g]),  32'(rdone && !own));
      check($sformatf("i%0d.d_rvalid", g),  32'(d_rvalid[g]),  32'(rdone && own));
      check($sformatf("i%0d.c_rdata", g),   32'(c_rdata[g]),   32'(erd_c));
      check($sformatf("i%0d.d_rdata", g),   32'(d_rdata[g]),   32'(erd_d));
      if (rst_n) begin
        if (busy) begin
          k++;
          if (owe ? (k == 2) : (k == L + 3)) busy = 0;
        end else if (gc || gd) begin
          busy   = 1;
          k      = 1;
          own    = gd;
          owe    = gd ? d_we[g] : c_we[g];
          ma     = gd ? d_addr[g] : c_addr[g];
          mwd    = gd ? d_wdata[g] : c_wdata[g];
          last_d = gd;
          if (owe) ref_mem[ma] = mwd;
        end
      end
    end
  end

  int en1 = 0;
  always @(negedge clk) if (mem_en[1]) en1++;

  task automatic set_req(input int i, input bit port, input bit v, input bit we,
                         input logic [7:0] a, input logic [15:0] wd);
    if (port) begin
      d_req[i] = v; d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd;
    end else begin
      c_req[i] = v; c_we[i] = we; c_addr[i] = a; c_wdata[i] = wd;
    end
  endtask

  task automatic access(input int i, input bit port, input bit we, input logic [7:0] a,
                        input logic [15:0] wd, output int gcyc, output int rcyc,
                        output logic [15:0] rdat);
    bit got;
    got = 0; gcyc = -1; rcyc = -1; rdat = 16'h0;
    set_req(i, port, 1'b1, we, a, wd);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (port ? d_gnt[i] : c_gnt[i]) begin
        got = 1;
        gcyc = cyc;
      end
    end
    @(posedge clk); #1;
    set_req(i, port, 1'b0, 1'b0, 8'h00, 16'h0000);
    if (!got) begin
      check("gnt_timeout", 32'd0, 32'd1);
      return;
    end
    if (!we) begin
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (port ? d_rvalid[i] : c_rvalid[i]) begin
          got = 1;
          rcyc = cyc;
          rdat = port ? d_rdata[i] : c_rdata[i];
        end
      end
      if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int gc, rc, en0, nrv, rv_seen;
    logic [15:0] rd;
    int order[$];
    int exp3[3];
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;

    @(posedge clk); #1;
    check("rst_mem_en", 32'(mem_en[0]), 32'd0);
    check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
    check("rst_c_rdata", 32'(c_rdata[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic read, latency 1: gnt -> rvalid is 3 cycles.
    access(0, 1'b0, 1'b0, 8'h2A, 16'h0, gc, rc, rd);
    check("rd2a_lat", 32'(rc - gc), 32'd3);
    check("rd2a_data", 32'(rd), 32'd42);

    // Write then read back on port D.
    access(0, 1'b1, 1'b1, 8'h05, 16'hBEEF, gc, rc, rd);
    access(0, 1'b1, 1'b0, 8'h05, 16'h0, gc, rc, rd);
    check("wr_rd_beef", 32'(rd), 32'hBEEF);

    // Simultaneous requests, each requester drops after its grant.
    do_reset();
    set_req(0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h0);
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h02, 16'h0);
    nrv = 0;
    for (int n = 0; n < 40 && nrv < 2; n++) begin
      bit gcn, gdn;
      @(negedge clk);
      gcn = c_gnt[0];
      gdn = d_gnt[0];
      if (gcn) order.push_back(0);
      if (gdn) order.push_back(1);
      if (c_rvalid[0] || d_rvalid[0]) nrv++;
      @(posedge clk); #1;
      if (gcn) c_req[0] = 1'b0;
      if (gdn) d_req[0] = 1'b0;
    end
    check("tie2_done", 32'(nrv), 32'd2);
    check("tie2_n", 32'(order.size()), 32'd2);
    check("tie2_first", 32'(order.size() > 0 ? order[0] : 9), 32'd0);
    check("tie2_second", 32'(order.size() > 1 ? order[1] : 9), 32'd1);
    check("tie2_c_rdata", 32'(c_rdata[0]), 32'd1);
    check("tie2_d_rdata", 32'(d_rdata[0]), 32'd2);

    // Three back-to-back ties with both requests held.
    do_reset();
    order.delete();
    set_req(0, 1'b0, 1'b1, 1'b0, 8'h03, 16'h0);
    set_req(0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h0);
    for (int n = 0; n < 60 && order.size() < 3; n++) begin
      @(negedge clk);
      if (c_gnt[0]) order.push_back(0);
      if (d_gnt[0]) order.push_back(1);
    end
    @(posedge clk); #1;
    c_req[0] = 1'b0;
    d_req[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    exp3[0] = 0;
    exp3[1] = RR ? 1 : 0;
    exp3[2] = 0;
    check("tie3_n", 32'(order.size()), 32'd3);
    for (int j = 0; j < 3; j++)
      check($sformatf("tie3_%0d", j), 32'(j < order.size() ? order[j] : 9), 32'(exp3[j]));

    // Latency 3 instance.
    en0 = en1;
    access(1, 1'b0, 1'b0, 8'hFF, 16'h0, gc, rc, rd);
    check("lat3_lat", 32'(rc - gc), 32'd5);
    check("lat3_data", 32'(rd), 32'd255);
    check("lat3_en_cycles", 32'(en1 - en0), 32'd1);

    // Reset in the middle of a read.
    set_req(0, 1'b0, 1'b1, 1'b0, 8'h2A, 16'h0);
    @(negedge clk);
    check("mid_gnt", 32'(c_gnt[0]), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(mem_en[0]), 32'd0);
    check("mid_rst_rvalid", 32'(c_rvalid[0]), 32'd0);
    check("mid_rst_c_rdata", 32'(c_rdata[0]), 32'd0);
    check("mid_rst_addr", 32'(mem_addr[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b0, 1'b1, 1'b1, 8'h33, 16'h1234);
    @(negedge clk);
    check("post_rst_gnt", 32'(c_gnt[0]), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0);
    rv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_rvalid[0] || d_rvalid[0]) rv_seen++;
    end
    check("post_rst_no_rvalid", 32'(rv_seen), 32'd0);

    access(0, 1'b0, 1'b0, 8'h33, 16'h0, gc, rc, rd);
    check("post_rst_rd", 32'(rd), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
